peripheral_seqalu: RTL
======================

Name: peripheral_seqalu

Overview:
Multi-cycle arithmetic unit directly downstream of the operand-capture stage. It takes the 32-bit operands dataA/dataB assembled from the switch bytes and starts on the rising edge of that stage's inputdata_ready. It computes ADD, SUB, MUL or DIV. It returns dataR (and a remainder) to the operand stage, which reads the result back byte by byte for display.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥ 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
start  input  1  level request (wired to inputdata_ready); only its rising edge is used
opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
dataA  input  WIDTH  operand A
dataB  input  WIDTH  operand B
dataR  output  WIDTH  result (sum/difference/low product/quotient)
dataRem  output  WIDTH  DIV remainder; 0 for other ops
busy  output  1  high from the accepted start edge until done
done  output  1  one-cycle pulse when results/flags update
zero  output  1  dataR == 0
carry  output  1  ADD carry-out; SUB borrow (A<B unsigned); MUL high half nonzero; DIV 0
divzero  output  1  DIV with dataB == 0

Behaviour:
- Reset (async): state IDLE, all outputs 0, internal registers 0. The start-history register resets to 1, so a start held high through reset never triggers; a fresh 0→1 edge is required.
- Edge detect: start_edge = start & ~start_q; start_q is registered every clk.
- FSM states: IDLE, RUN, FIN.
  - IDLE: on start_edge, latch dataA, dataB and opcode into internal registers; busy←1; counter←0; go to RUN. Later changes on operand/opcode inputs are ignored.
  - RUN, ADD/SUB: compute on the WIDTH+1-bit extended operands; go to FIN after 1 cycle.
  - RUN, MUL: unsigned shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator, exactly WIDTH cycles.
  - RUN, DIV: unsigned restoring division, one quotient bit per cycle, exactly WIDTH cycles.
  - RUN, DIV with latched B == 0: skip iteration, go to FIN after 1 cycle.
  - FIN: register dataR, dataRem, zero, carry, divzero; done←1 for this cycle only; busy←0; go to IDLE.
- Latency, counting the clk edge that samples start_edge as edge 0: outputs update and done pulses after edge 2 for ADD, SUB and DIV-by-zero, and after edge WIDTH+2 for MUL/DIV.
- Output holding: outputs keep their last values until the next FIN; they are not cleared on a new start.
- start_edge while busy (RUN/FIN) is ignored, not queued. A start that stays high after done does not retrigger.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - MUL dataR = low WIDTH bits of the product.
  - DIV by zero: dataR = all ones, dataRem = latched A, divzero=1, carry=0.
  - zero is derived from the final dataR value.
- Reset mid-operation aborts immediately; no done is issued.

Optional Feature:
SEQALU_DIV_EN
- Defined: DIV implemented as described above.
- Undefined: divider logic is not compiled. Opcode 11 completes with ADD latency: dataR=0, dataRem=0, zero=1, carry=0, divzero=1 (flags "unsupported"). Other ops are unchanged.

Test Plan:
1. ADD A=0xFFFFFFFF, B=0x00000001, start 0→1 → after edge 2: dataR=0, zero=1, carry=1, one-cycle done, busy high in between.
2. SUB A=5, B=7 → dataR=0xFFFFFFFE, carry=1, zero=0. Then SUB A=7, B=7 → dataR=0, zero=1, carry=0.
3. MUL A=1234, B=5678 → dataR=0x006AE9BC, carry=0, done after edge 34. Then A=0x00010000, B=0x00010000 → dataR=0, zero=1, carry=1.
4. DIV A=100, B=7 → dataR=14, dataRem=2, done after edge 34. Then DIV A=0x55, B=0 → dataR=0xFFFFFFFF, dataRem=0x55, divzero=1, done after edge 2. Without SEQALU_DIV_EN, DIV 100/7 → dataR=0, divzero=1, edge 2.
5. Start held high 50 cycles after a completed ADD → no second done. Start toggled 0→1 at edge 10 of a MUL → ignored; exactly one done at edge 34; operand changes mid-run do not alter the result.
6. Reset asserted at edge 10 of a MUL with start held high → all outputs 0 asynchronously. After reset release, no operation until start goes 0 then 1; the following ADD 2+3 gives dataR=5.

Source files
------------

// File: rtl/peripheral_seqalu_if.sv
// Operand/result bundle between the operand-capture stage (master) and the
// sequential ALU (slave).
interface peripheral_seqalu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataR;
  logic [WIDTH-1:0] dataRem;
  logic             busy;
  logic             done;
  logic             zero;
  logic             carry;
  logic             divzero;

  modport master (
    output start, opcode, dataA, dataB,
    input  dataR, dataRem, busy, done, zero, carry, divzero
  );

  modport slave (
    input  start, opcode, dataA, dataB,
    output dataR, dataRem, busy, done, zero, carry, divzero
  );
endinterface

// File: rtl/peripheral_seqalu.sv
// Multi-cycle ADD/SUB/MUL/DIV unit started by a rising edge of bus.start.
// Define SEQALU_DIV_EN to build the restoring divider; otherwise DIV reports "unsupported".
module peripheral_seqalu #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  peripheral_seqalu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   rem_out_q, rem_out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               divzero_q, divzero_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               start_edge;
  logic               iter_last;
  logic [WIDTH:0]     addsub;
  logic [WIDTH:0]     mul_sum;
`ifdef SEQALU_DIV_EN
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
`endif

  assign bus.dataR   = r_q;
  assign bus.dataRem = rem_out_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.divzero = divzero_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

  // Datapath helpers: one ADD/SUB, one shift-add step, one restoring-divide step.
  always_comb begin
    start_edge = bus.start & ~start_q;
    iter_last  = (cnt_q == CNT_W'(WIDTH));
    if (op_q == OP_SUB) begin
      addsub = {1'b0, a_q} - {1'b0, b_q};
    end else begin
      addsub = {1'b0, a_q} + {1'b0, b_q};
    end
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
`ifdef SEQALU_DIV_EN
    div_shift = {rem_q, a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
`endif
  end

  always_comb begin
    state_d   = state_q;
    start_d   = bus.start;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    r_d       = r_q;
    rem_out_d = rem_out_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
`ifdef SEQALU_DIV_EN
    rem_d     = rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          a_d     = bus.dataA;
          b_d     = bus.dataB;
          op_d    = bus.opcode;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, bus.dataB};
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef SEQALU_DIV_EN
          rem_d   = '0;
`endif
        end
      end

      RUN: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d   = {{(WIDTH-1){1'b0}}, addsub};
            state_d = FIN;
          end
          // Multiplier sits in the low half and shifts out as the product shifts in.
          OP_MUL: begin
            if (iter_last) begin
              state_d = FIN;
            end else begin
              acc_d = {mul_sum, acc_q[WIDTH-1:1]};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          OP_DIV: begin
`ifdef SEQALU_DIV_EN
            // Dividend shifts out of a_q while quotient bits shift in behind it.
            if (b_q == '0 || iter_last) begin
              state_d = FIN;
            end else begin
              if (div_diff[WIDTH]) begin
                rem_d = div_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b0};
              end else begin
                rem_d = div_diff[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], 1'b1};
              end
              cnt_d = cnt_q + CNT_W'(1);
            end
`else
            state_d = FIN;
`endif
          end
          default: state_d = FIN;
        endcase
      end

      FIN: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        rem_out_d = '0;
        carry_d   = 1'b0;
        divzero_d = 1'b0;
        case (op_q)
          OP_ADD, OP_SUB: begin
            r_d     = acc_q[WIDTH-1:0];
            carry_d = acc_q[WIDTH];
          end
          OP_MUL: begin
            r_d     = acc_q[WIDTH-1:0];
            carry_d = |acc_q[2*WIDTH-1:WIDTH];
          end
          default: begin
`ifdef SEQALU_DIV_EN
            if (b_q == '0) begin
              r_d       = '1;
              rem_out_d = a_q;
              divzero_d = 1'b1;
            end else begin
              r_d       = a_q;
              rem_out_d = rem_q;
            end
`else
            r_d       = '0;
            divzero_d = 1'b1;
`endif
          end
        endcase
        zero_d = (r_d == '0);
      end

      default: state_d = IDLE;
    endcase
  end

  // start_q resets high so a start level held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b1;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      r_q       <= '0;
      rem_out_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SEQALU_DIV_EN
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      rem_out_q <= rem_out_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef SEQALU_DIV_EN
      rem_q     <= rem_d;
`endif
    end
  end
endmodule
